// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit line among NREQ requesters: round-robin grant with an
// optional per-owner lock, 8N1 serialisation and a one-cycle done pulse per byte.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNTW         = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [8*NREQ-1:0]   data,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic                out_uart_txd,
  output logic                busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [IW-1:0]   rr;
  logic [IW-1:0]   owner;
  logic            own_lock;

  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   idx;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
  endfunction

  // Winner for this IDLE cycle: the locked owner only, else first request from rr.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = owner;
    idx       = rr;
    if (own_lock) begin
      win_valid = req[owner];
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!win_valid && req[idx]) begin
          win_valid = 1'b1;
          win_idx   = idx;
        end
        idx = next_idx(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rr           <= '0;
      owner        <= '0;
      own_lock     <= 1'b0;
      grant        <= '0;
      done         <= '0;
      out_uart_txd <= 1'b1;
      busy         <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          out_uart_txd <= 1'b1;
          if (win_valid) begin
            shift        <= data[{win_idx, 3'b000} +: 8];
            grant        <= NREQ'(1) << win_idx;
            owner        <= win_idx;
            cnt          <= BIT_LAST;
            out_uart_txd <= 1'b0;
            busy         <= 1'b1;
            state        <= START;
          end else if (own_lock && !lock[owner]) begin
            own_lock <= 1'b0;
            rr       <= next_idx(owner);
          end
        end

        START: begin
          if (cnt == '0) begin
            out_uart_txd <= shift[0];
            bit_idx      <= '0;
            cnt          <= BIT_LAST;
            state        <= DATA;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end

        DATA: begin
          if (cnt == '0) begin
            cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              out_uart_txd <= 1'b1;
              state        <= STOP;
            end else begin
              shift        <= shift >> 1;
              out_uart_txd <= shift[1];
              bit_idx      <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end

        STOP: begin
          // done is raised one cycle early so it lands on the final stop cycle.
          if (cnt == '0) begin
            grant    <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
            own_lock <= lock[owner];
            if (!lock[owner]) begin
              rr <= next_idx(owner);
            end
          end else begin
            cnt <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) begin
              done <= grant;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written lock/reset
// sequences and random traffic, all checked cycle by cycle against a frame-timer model.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int CPB   = 4;
  localparam int CNTW  = 4;
  localparam int FRAME = 10 * CPB;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              txd;
  logic              busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .CLKS_PER_BIT(CPB),
    .CNTW        (CNTW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .lock        (lock),
    .data        (data),
    .grant       (grant),
    .done        (done),
    .out_uart_txd(txd),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is a timer t running 0..FRAME-1 from grant; the
  // line value is a pure function of t / CPB and the captured byte.
  bit        m_active = 1'b0;
  int        m_t      = 0;
  int        m_owner  = 0;
  int        m_rr     = 0;
  bit        m_lock   = 1'b0;
  logic [7:0] m_byte  = 8'h00;
  int        m_w;
  bit        m_found;
  logic [NREQ-1:0]   m_rsh;
  logic [8*NREQ-1:0] m_dsh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_t      = 0;
      m_owner  = 0;
      m_rr     = 0;
      m_lock   = 1'b0;
      m_byte   = 8'h00;
    end else if (m_active) begin
      if (m_t == FRAME - 1) begin
        m_active = 1'b0;
        m_rsh    = lock >> m_owner;
        m_lock   = m_rsh[0];
        if (!m_lock) m_rr = (m_owner + 1) % NREQ;
      end else begin
        m_t = m_t + 1;
      end
    end else begin
      m_found = 1'b0;
      m_w     = 0;
      if (m_lock) begin
        m_rsh = req >> m_owner;
        if (m_rsh[0]) begin
          m_found = 1'b1;
          m_w     = m_owner;
        end else begin
          m_rsh = lock >> m_owner;
          if (!m_rsh[0]) begin
            m_lock = 1'b0;
            m_rr   = (m_owner + 1) % NREQ;
          end
        end
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          m_rsh = req >> ((m_rr + i) % NREQ);
          if (!m_found && m_rsh[0]) begin
            m_found = 1'b1;
            m_w     = (m_rr + i) % NREQ;
          end
        end
      end
      if (m_found) begin
        m_active = 1'b1;
        m_t      = 0;
        m_owner  = m_w;
        m_dsh    = data >> (8 * m_w);
        m_byte   = m_dsh[7:0];
      end
    end
  end

  function automatic logic [9:0] exp_out();
    logic [3:0] g;
    logic [7:0] sh;
    logic       t;
    int         bp;
    g  = m_active ? (4'b0001 << m_owner) : 4'b0000;
    bp = m_t / CPB;
    sh = 8'h00;
    if (!m_active)    t = 1'b1;
    else if (bp == 0) t = 1'b0;
    else if (bp >= 9) t = 1'b1;
    else begin
      sh = m_byte >> (bp - 1);
      t  = sh[0];
    end
    return {g, (m_active && m_t == FRAME - 1) ? g : 4'b0000, m_active, t};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock: sample away from the active edge and compare against the model.
  task automatic tick();
    @(negedge clk);
    check("cycle", {22'b0, grant, done, busy, txd}, {22'b0, exp_out()});
  endtask

  // Called at the grant cycle (t=0); returns the byte read at mid-bits and the done cycle.
  task automatic frame(output logic [7:0] b, output int dt);
    b  = 8'h00;
    dt = -1;
    for (int t = 0; t < FRAME; t++) begin
      if (t > 0) tick();
      if (done != '0 && dt < 0) dt = t;
      if ((t % CPB) == CPB / 2 && t / CPB >= 1 && t / CPB <= 8) b = {txd, b[7:1]};
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    req  = '0;
    lock = '0;
    tick();
    tick();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] b;
  int         dt;

  initial begin
    vecs[0] = '{4'b0001, 32'h0FA53C48, 4'b0001, 8'h48};
    vecs[1] = '{4'b1111, 32'h0FA53C48, 4'b0010, 8'h3C};
    vecs[2] = '{4'b0001, 32'h0FA53C48, 4'b0001, 8'h48};
    vecs[3] = '{4'b1001, 32'h0FA53C48, 4'b1000, 8'h0F};
    vecs[4] = '{4'b1100, 32'h0FA53C48, 4'b0100, 8'hA5};
    vecs[5] = '{4'b0110, 32'h0FA53C48, 4'b0010, 8'h3C};
    vecs[6] = '{4'b0011, 32'h0FA5FF00, 4'b0001, 8'h00};
    vecs[7] = '{4'b0010, 32'h0FA5FF00, 4'b0010, 8'hFF};

    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    data  = '0;
    repeat (3) tick();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("reset_state", {22'b0, grant, done, busy, txd}, 32'h1);

    // Single-cycle request pulses walking the rr pointer.
    for (int i = 0; i < 8; i++) begin
      req  = vecs[i].req;
      data = vecs[i].data;
      tick();
      check("vec_grant", {28'b0, grant}, {28'b0, vecs[i].exp_grant});
      req = '0;
      frame(b, dt);
      check("vec_byte", {24'b0, b}, {24'b0, vecs[i].exp_byte});
      check("vec_done_cycle", dt, FRAME - 1);
      tick();
      check("vec_idle", {27'b0, grant, busy}, 32'h0);
      repeat (3) tick();
      check("vec_no_regrant", {28'b0, grant}, 32'h0);
    end

    // Held contention on requesters 1 and 3: alternate with one idle cycle between.
    do_reset();
    req  = 4'b1010;
    data = 32'h11223344;
    tick();
    check("rr_grant", {28'b0, grant}, 32'h2);
    for (int f = 0; f < 4; f++) begin
      frame(b, dt);
      check("rr_done_cycle", dt, FRAME - 1);
      if (f == 3) req = '0;
      tick();
      check("rr_gap", {28'b0, grant}, 32'h0);
      tick();
      check("rr_next", {28'b0, grant}, (f == 3) ? 32'h0 : ((f % 2 == 0) ? 32'h8 : 32'h2));
    end

    // Locked owner sends two bytes back to back before requester 0 gets in.
    do_reset();
    req  = 4'b0100;
    lock = 4'b0100;
    data = 32'h000D0055;
    tick();
    check("lock_grant1", {28'b0, grant}, 32'h4);
    req  = 4'b0101;
    data = 32'h000A0055;
    frame(b, dt);
    check("lock_byte1", {24'b0, b}, 32'h0D);
    tick();
    check("lock_gap", {28'b0, grant}, 32'h0);
    tick();
    check("lock_grant2", {28'b0, grant}, 32'h4);
    lock = 4'b0000;
    req  = 4'b0001;
    frame(b, dt);
    check("lock_byte2", {24'b0, b}, 32'h0A);
    tick();
    tick();
    check("lock_grant3", {28'b0, grant}, 32'h1);
    frame(b, dt);
    check("lock_byte3", {24'b0, b}, 32'h55);
    req = '0;
    tick();

    // Locked owner idles without a request; releasing lock hands over to 3.
    do_reset();
    req  = 4'b0010;
    lock = 4'b0010;
    data = 32'h00003C00;
    tick();
    check("hold_grant", {28'b0, grant}, 32'h2);
    req = 4'b1000;
    frame(b, dt);
    tick();
    repeat (3) tick();
    check("hold_line", {28'b0, grant}, 32'h0);
    lock = 4'b0000;
    tick();
    check("release_cycle", {28'b0, grant}, 32'h0);
    tick();
    check("release_grant", {28'b0, grant}, 32'h8);
    req = '0;
    frame(b, dt);
    tick();

    // Asynchronous reset during data bit 3, then a clean frame from rr=0.
    do_reset();
    req  = 4'b0001;
    data = 32'h000000C3;
    tick();
    check("mid_grant", {28'b0, grant}, 32'h1);
    req = '0;
    repeat (4 * CPB + 1) tick();
    check("mid_busy_before", {31'b0, busy}, 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_async", {22'b0, grant, done, busy, txd}, 32'h1);
    tick();
    tick();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    req  = 4'b0001;
    data = 32'h0000005A;
    tick();
    check("post_reset_grant", {28'b0, grant}, 32'h1);
    req = '0;
    frame(b, dt);
    check("post_reset_byte", {24'b0, b}, 32'h5A);
    check("post_reset_done", dt, FRAME - 1);
    tick();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 7) == 0)  req  = req ^ (4'b0001 << k);
        if ($urandom_range(0, 15) == 0) lock = lock ^ (4'b0001 << k);
      end
      data = $urandom();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
